// File: rtl/inst_mem_loader.sv
// Instruction memory loader: assembles big-endian words from a byte stream and writes them from address 0.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module inst_mem_loader #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_error,
   output logic [ADDR_W:0]   o_words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEADER = 3'd1,
      S_RECV   = 3'd2,
      S_WRITE  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK  = 3'd4,
`endif
      S_DONE   = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_rx_ready;
   logic              r_mem_we;
   logic [31:0]       r_word;
   logic [1:0]        r_byte_idx;
   logic [ADDR_W:0]   r_words;
   logic [ADDR_W:0]   r_n;
   logic              r_hold;
   logic              r_done;
   logic              r_error;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   logic              w_xfer;
   logic              w_hdr_bad;
   logic [31:0]       w_hdr_ext;
   logic [ADDR_W:0]   w_words_inc;
   logic              w_last;

   assign w_xfer      = i_rx_valid & r_rx_ready;
   assign w_hdr_ext   = {24'd0, i_rx_data};
   assign w_hdr_bad   = (i_rx_data == 8'd0) || (w_hdr_ext > 32'(DEPTH));
   assign w_words_inc = r_words + {{ADDR_W{1'b0}}, 1'b1};
   assign w_last      = (w_words_inc == r_n);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_HEADER;
            else         w_next = S_IDLE;
         end
         S_HEADER: begin
            if (w_xfer) w_next = w_hdr_bad ? S_DONE : S_RECV;
            else        w_next = S_HEADER;
         end
         S_RECV: begin
            if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            else                                 w_next = S_RECV;
         end
         S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
            if (w_last) w_next = S_CHECK;
`else
            if (w_last) w_next = S_DONE;
`endif
            else        w_next = S_RECV;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (w_xfer) w_next = S_DONE;
            else        w_next = S_CHECK;
         end
`endif
         S_DONE: begin
            if (i_start) w_next = S_HEADER;
            else         w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake and write strobe are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_ready <= 1'b0;
         r_mem_we   <= 1'b0;
      end else begin
`ifdef LOADER_CHECKSUM_EN
         r_rx_ready <= (w_next == S_HEADER) || (w_next == S_RECV) || (w_next == S_CHECK);
`else
         r_rx_ready <= (w_next == S_HEADER) || (w_next == S_RECV);
`endif
         r_mem_we   <= (w_next == S_WRITE);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word     <= 32'd0;
         r_byte_idx <= 2'd0;
         r_words    <= '0;
         r_n        <= '0;
         r_hold     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_xor      <= 8'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_words    <= '0;
                  r_hold     <= 1'b1;
                  r_byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                  r_xor      <= 8'd0;
`endif
               end
            end
            S_HEADER: begin
               if (w_xfer) begin
                  if (w_hdr_bad) begin
                     r_error <= 1'b1;
                     r_hold  <= 1'b0;
                  end else begin
                     r_n <= w_hdr_ext[ADDR_W:0];
                  end
               end
            end
            S_RECV: begin
               // Shifting left places the first byte of each word in bits [31:24].
               if (w_xfer) begin
                  r_word     <= {r_word[23:0], i_rx_data};
                  r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  r_xor      <= r_xor ^ i_rx_data;
`endif
               end
            end
            S_WRITE: begin
               r_words <= w_words_inc;
`ifdef LOADER_CHECKSUM_EN
`else
               if (w_last) begin
                  r_done <= 1'b1;
                  r_hold <= 1'b0;
               end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (w_xfer) begin
                  r_hold <= 1'b0;
                  if (i_rx_data == r_xor) r_done  <= 1'b1;
                  else                    r_error <= 1'b1;
               end
            end
`endif
            default: begin
               r_hold <= r_hold;
            end
         endcase
      end
   end

   assign o_rx_ready     = r_rx_ready;
   assign o_mem_we       = r_mem_we;
   assign o_mem_addr     = r_words[ADDR_W-1:0];
   assign o_mem_wdata    = r_word;
   assign o_cpu_hold     = r_hold;
   assign o_done         = r_done;
   assign o_error        = r_error;
   assign o_words_loaded = r_words;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued from a byte-level model and popped by a write monitor.
module tb_inst_mem_loader;
   localparam int DEPTH  = 128;
   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              i_rst, i_start, i_rx_valid;
   logic [7:0]        i_rx_data;
   logic              o_rx_ready, o_mem_we, o_cpu_hold, o_done, o_error;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata;
   logic [ADDR_W:0]   o_words_loaded;

   always #5 clk = ~clk;

   inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_rx_data(i_rx_data),
      .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_cpu_hold(o_cpu_hold),
      .o_done(o_done), .o_error(o_error), .o_words_loaded(o_words_loaded)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   int          n_checks = 0;
   int          n_errors = 0;
   wr_t         exp_q[$];
   wr_t         got;
   logic [31:0] mem_model [DEPTH];
   logic [31:0] mem_ref   [DEPTH];
   logic        prev_we = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired, expected DUT event", nm);
   endtask

   // Write monitor: every strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (o_mem_we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", o_mem_addr, o_mem_wdata);
         end else begin
            got = exp_q.pop_front();
            chk("wr_addr", {57'd0, o_mem_addr}, {57'd0, got.a});
            chk("wr_data", {32'd0, o_mem_wdata}, {32'd0, got.d});
         end
         chk("we_one_cycle", {63'd0, prev_we}, 64'd0);
         mem_model[o_mem_addr] = o_mem_wdata;
      end
      prev_we = o_mem_we;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int g;
      bit ok;
      g = $urandom_range(maxgap, 0);
      repeat (g) tick();
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if (o_rx_ready) ok = 1'b1;
         tick();
      end
      i_rx_valid = 1'b0;
      if (!ok) fail("rx_ready_wait");
   endtask

   task automatic check_reset_vals();
      @(negedge clk);
      chk("rst_rx_ready", {63'd0, o_rx_ready}, 64'd0);
      chk("rst_mem_we",   {63'd0, o_mem_we},   64'd0);
      chk("rst_mem_addr", {57'd0, o_mem_addr}, 64'd0);
      chk("rst_wdata",    {32'd0, o_mem_wdata}, 64'd0);
      chk("rst_cpu_hold", {63'd0, o_cpu_hold}, 64'd0);
      chk("rst_done",     {63'd0, o_done},     64'd0);
      chk("rst_error",    {63'd0, o_error},    64'd0);
      chk("rst_words",    {56'd0, o_words_loaded}, 64'd0);
   endtask

   // Reference model: a valid header N yields N big-endian words at addresses 0..N-1.
   task automatic run_load(input int n_hdr, input logic [7:0] data[$], input int maxgap,
                           input bit bad_ck, input bit start_in_recv);
      bit          hdr_ok;
      bit          seen;
      bit          exp_ok;
      logic [7:0]  ck;
      logic [31:0] w;
      hdr_ok = (n_hdr >= 1) && (n_hdr <= DEPTH);
      ck = 8'd0;
      if (hdr_ok) begin
         for (int i = 0; i < n_hdr; i++) begin
            w = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
            exp_q.push_back('{a: ADDR_W'(i), d: w});
            mem_ref[i] = w;
            ck = ck ^ data[4*i] ^ data[4*i+1] ^ data[4*i+2] ^ data[4*i+3];
         end
      end
      pulse_start();
      chk("hold_on_start", {63'd0, o_cpu_hold}, 64'd1);
      chk("done_cleared",  {63'd0, o_done},     64'd0);
      send_byte(8'(n_hdr), maxgap);
      if (hdr_ok) begin
         for (int j = 0; j < 4 * n_hdr; j++) begin
            send_byte(data[j], maxgap);
            if (start_in_recv && (j == 1)) begin
               pulse_start();
               chk("idle_start_words", {56'd0, o_words_loaded}, 64'd0);
            end
         end
`ifdef LOADER_CHECKSUM_EN
         send_byte(bad_ck ? (ck ^ 8'h01) : ck, maxgap);
`endif
      end
      exp_ok = hdr_ok && !bad_ck;
      seen = 1'b0;
      for (int k = 0; k < 32 && !seen; k++) begin
         @(negedge clk);
         if (o_done || o_error) seen = 1'b1;
      end
      if (!seen) fail("load_end_wait");
      chk("end_done",     {63'd0, o_done},     {63'd0, exp_ok});
      chk("end_error",    {63'd0, o_error},    {63'd0, !exp_ok});
      chk("end_words",    {56'd0, o_words_loaded}, hdr_ok ? 64'(n_hdr) : 64'd0);
      chk("end_cpu_hold", {63'd0, o_cpu_hold}, 64'd0);
      chk("end_rx_ready", {63'd0, o_rx_ready}, 64'd0);
      chk("sb_drained",   64'(exp_q.size()),   64'd0);
      tick();
      tick();
      chk("post_rx_ready", {63'd0, o_rx_ready}, 64'd0);
   endtask

   logic [7:0] bytes[$];
   int         mism;
   int         n;

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_model[i] = 32'd0;
         mem_ref[i]   = 32'd0;
      end
      tick();
      tick();
      i_rst = 1'b0;
      check_reset_vals();
      tick();

      bytes = '{8'h01, 8'hCE, 8'h70, 8'h22, 8'h0C, 8'h82, 8'h02, 8'h00};
      run_load(2, bytes, 0, 1'b0, 1'b0);
      chk("dir_word0", {32'd0, mem_model[0]}, 64'h01CE7022);
      chk("dir_word1", {32'd0, mem_model[1]}, 64'h0C820200);

      bytes = {};
      run_load(0, bytes, 1, 1'b0, 1'b0);
      run_load(129, bytes, 1, 1'b0, 1'b0);

      bytes = {};
      for (int i = 0; i < 4 * DEPTH; i++) bytes.push_back(8'($urandom));
      run_load(DEPTH, bytes, 3, 1'b0, 1'b0);
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (mem_model[i] !== mem_ref[i]) mism++;
      chk("full_mem_contents", 64'(mism), 64'd0);

      bytes = {};
      for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
      run_load(2, bytes, 1, 1'b0, 1'b1);

      // Reset during the second word: word 0 stays written, nothing else appears.
      bytes = {};
      for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
      exp_q.push_back('{a: ADDR_W'(0), d: {bytes[0], bytes[1], bytes[2], bytes[3]}});
      pulse_start();
      send_byte(8'd3, 0);
      for (int j = 0; j < 6; j++) send_byte(bytes[j], 1);
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_reset_vals();
      tick();
      repeat (4) tick();
      chk("rst_sb_drained", 64'(exp_q.size()), 64'd0);
      chk("rst_word0_kept", {32'd0, mem_model[0]}, {32'd0, bytes[0], bytes[1], bytes[2], bytes[3]});

      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(8, 1);
         bytes = {};
         for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
         run_load(n, bytes, 2, 1'b0, 1'b0);
      end

`ifdef LOADER_CHECKSUM_EN
      bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
      run_load(1, bytes, 0, 1'b0, 1'b0);
      run_load(1, bytes, 0, 1'b1, 1'b0);
      chk("ck_word_kept", {32'd0, mem_model[0]}, 64'h12345678);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes each word into the instruction memory array through a single write port, starting at word address 0. Holds the processor core in stall while loading and replaces the hard-coded initial program image at run time.

Parameters:
DEPTH, 128, number of 32-bit words in the instruction memory
ADDR_W, 7, width of word address; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  write strobe to instruction memory, one cycle per word
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  instruction word to write
cpu_hold  output  1  stall the core / hold its PC at 0
done  output  1  load finished successfully; sticky until next start or rst
error  output  1  load aborted; sticky until next start or rst
words_loaded  output  ADDR_W+1  count of words written in the current or last load

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Byte transfer occurs on a cycle where rx_valid=1 and rx_ready=1.
- On rst: state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, words_loaded=0, byte index=0.
- If rst is asserted mid-load, the load aborts with no further writes. Words already written stay in memory.
- States:
  - IDLE: rx_ready=0. start -> HEADER; clear done, error and words_loaded; set cpu_hold=1.
  - HEADER: rx_ready=1. The accepted byte is the word count N.
    - N=0 or N>DEPTH -> DONE with error=1.
    - Otherwise latch N -> RECV.
  - RECV: rx_ready=1. Bytes arrive MSB first; byte index 0..3 fills bits [31:24], [23:16], [15:8], [7:0]. On the 4th accepted byte -> WRITE.
  - WRITE: rx_ready=0 for exactly one cycle. mem_we=1, mem_addr=words_loaded[ADDR_W-1:0], mem_wdata=assembled word. words_loaded increments at the end of this cycle.
    - If the new count equals N -> CHECK (feature enabled) or DONE.
    - Otherwise -> RECV.
  - CHECK: described under Optional Feature.
  - DONE: rx_ready=0, cpu_hold=0. done=1 unless error. start -> HEADER as from IDLE.
- Timing:
  - Byte-to-write latency: mem_we asserts the cycle after the 4th byte handshake.
  - Minimum 5 cycles per word at full rx rate.
- rx_valid gaps stall the state machine in place; partial words are retained indefinitely. There is no timeout.
- start while in HEADER, RECV, WRITE or CHECK is ignored.
- mem_addr never wraps: N<=DEPTH guarantees the last address is DEPTH-1.
- mem_we is never asserted outside WRITE.
- Memory write port contract: a write at posedge with mem_we=1 updates memdata[mem_addr]. The loader tolerates the memory's one-cycle registered read.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the Nth WRITE, go to CHECK with rx_ready=1. Accept one byte equal to the XOR of all 4N data bytes; the header byte is excluded.
  - Match -> DONE with done=1. Mismatch -> DONE with error=1. Data already written is not rolled back.
  - A running XOR register (8 bits) clears on start.
- Undefined: no CHECK state and no XOR register; DONE follows the Nth WRITE directly.

Test Plan:
- rst, start, header 0x02, bytes 01 CE 70 22 0C 82 02 00 -> writes at addr 0: 0x01CE7022 and addr 1: 0x0C820200. Each mem_we is 1 cycle; done=1, words_loaded=2, cpu_hold falls with done.
- Header 0x00, then a separate load with header 0x81 (DEPTH=128) -> error=1, done=0, no mem_we, rx_ready=0 afterwards.
- Full 128-word load with random rx_valid gaps -> last write at addr 127 and no addr 0 rewrite; memory contents match the stream.
- rst asserted after 2 bytes of word 1 -> all outputs at reset values next cycle, no write. Word 0 remains in memory; a new start reloads cleanly.
- start pulses during RECV -> ignored; byte index and words_loaded are unaffected.
- With LOADER_CHECKSUM_EN: header 0x01, bytes 12 34 56 78, checksum 0x08 -> done=1; repeat with checksum 0x09 -> error=1 and the word is still written.
